// File: rtl/operand_fetch_if.sv
// operand_fetch_if: fetch-side, register-bank and execute-side signals of the decode operand reader.
//   slave  : operand_fetch view (decode stage)
//   master : driving side (fetch, register bank, writeback, execute)
//   Fetch handshake : in_valid, in_ready, instr, pc_in
//   Bank read       : rs1_addr, rs2_addr, rdata1, rdata2
//   Writeback       : wb_ena, wb_reg, wb_data
//   Execute         : ex_is_load, ex_rd, out_valid, out_ready, op_a, op_b, imm, rd_out, pc_out, opcode_out
interface operand_fetch_if #(
    parameter int size = 32,
    parameter int addr_w = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [size-1:0]   instr;
    logic [size-1:0]   pc_in;
    logic [addr_w-1:0] rs1_addr;
    logic [addr_w-1:0] rs2_addr;
    logic [size-1:0]   rdata1;
    logic [size-1:0]   rdata2;
    logic              wb_ena;
    logic [addr_w-1:0] wb_reg;
    logic [size-1:0]   wb_data;
    logic              ex_is_load;
    logic [addr_w-1:0] ex_rd;
    logic              out_valid;
    logic              out_ready;
    logic [size-1:0]   op_a;
    logic [size-1:0]   op_b;
    logic [size-1:0]   imm;
    logic [addr_w-1:0] rd_out;
    logic [size-1:0]   pc_out;
    logic [6:0]        opcode_out;
    modport slave (
        input  in_valid, instr, pc_in, rdata1, rdata2, wb_ena, wb_reg, wb_data,
               ex_is_load, ex_rd, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, op_a, op_b, imm, rd_out,
               pc_out, opcode_out
    );
    modport master (
        output in_valid, instr, pc_in, rdata1, rdata2, wb_ena, wb_reg, wb_data,
               ex_is_load, ex_rd, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, op_a, op_b, imm, rd_out,
               pc_out, opcode_out
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: RV32I decode-stage operand reader with writeback bypass, load-use bubble and ID/EX register.
//   CLK   : clock
//   aRSTn : asynchronous active-low reset
//   bus   : operand_fetch_if.slave (fetch handshake, bank read ports, writeback, execute handshake)
module operand_fetch #(
    parameter int size = 32,
    parameter int addr_w = 5
) (
    input logic            CLK,
    input logic            aRSTn,
    operand_fetch_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t            state, state_nx;
    logic [31:0]       ins;
    logic [6:0]        opc;
    logic [addr_w-1:0] rs1, rs2;
    logic              uses_rs1, uses_rs2, hazard, adv, take;
    logic [size-1:0]   val1, val2, imm_nx;
    logic [31:0]       imm32;

    assign ins      = bus.instr[31:0];
    assign opc      = ins[6:0];
    assign rs1      = ins[19:15];
    assign rs2      = ins[24:20];
    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;

    assign uses_rs1 = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign uses_rs2 = opc inside {OP_REG, OP_STORE, OP_BRANCH};

    // The bank write only lands at the next edge, so same-cycle writeback data is forwarded here.
    assign val1 = (bus.wb_ena && bus.wb_reg == rs1 && rs1 != '0) ? bus.wb_data :
                  (rs1 == '0) ? '0 : bus.rdata1;
    assign val2 = (bus.wb_ena && bus.wb_reg == rs2 && rs2 != '0) ? bus.wb_data :
                  (rs2 == '0) ? '0 : bus.rdata2;

    always_comb begin
        imm32 = '0;
        case (opc)
            OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:                 imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {ins[31:12], 12'b0};
            OP_JAL:                   imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default:                  imm32 = '0;
        endcase
    end

    assign imm_nx = size'($signed(imm32));

    assign adv    = !bus.out_valid || bus.out_ready;
    assign hazard = bus.in_valid && bus.ex_is_load && bus.ex_rd != '0 &&
                    ((uses_rs1 && bus.ex_rd == rs1) || (uses_rs2 && bus.ex_rd == rs2));
    // In BUBBLE the load has moved past execute; its result now arrives through the bypass.
    assign bus.in_ready = adv && !(state == RUN && hazard);
    assign take         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nx = state;
        if (state == BUBBLE)
            state_nx = RUN;
        else if (hazard && adv)
            state_nx = BUBBLE;
    end

    always_ff @(posedge CLK or negedge aRSTn) begin
        if (!aRSTn)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_ff @(posedge CLK or negedge aRSTn) begin
        if (!aRSTn) begin
            bus.out_valid  <= 1'b0;
            bus.op_a       <= '0;
            bus.op_b       <= '0;
            bus.imm        <= '0;
            bus.rd_out     <= '0;
            bus.pc_out     <= '0;
            bus.opcode_out <= '0;
        end else if (take) begin
            bus.out_valid  <= 1'b1;
            bus.op_a       <= val1;
            bus.op_b       <= val2;
            bus.imm        <= imm_nx;
            bus.rd_out     <= ins[11:7];
            bus.pc_out     <= bus.pc_in;
            bus.opcode_out <= opc;
        end else if (adv) begin
            bus.out_valid  <= 1'b0;
        end
    end
endmodule
